// File: rtl/fsk_symbol_sequencer.sv
// Serialises valid/ready data words MSB-first onto a one-bit FSK tone select at a programmable baud rate.
// Load is one edge after a word is accepted from idle; one-word buffer, Din_Ready low while it is occupied.
module fsk_symbol_sequencer #(
  parameter int   DATA_W   = 16,
  parameter int   DIV_W    = 32,
  parameter logic IDLE_LVL = 1'b1
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Enable,
  input  logic [DIV_W-1:0]  Baud_Div,
  input  logic [DATA_W-1:0] Din,
  input  logic              Din_Valid,
  output logic              Din_Ready,
  output logic              SW_Sel,
  output logic              Sym_Strobe,
  output logic              Busy,
  output logic              Underrun
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state;
  logic [DATA_W-1:0] buf_q;
  logic              buf_full;
  logic [DATA_W-1:0] sreg;
  logic [BW-1:0]     bcnt;
  logic [DIV_W-1:0]  dcnt;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  div_new;
  logic              word_end;
  logic              do_load;

  assign div_new   = (Baud_Div == '0) ? DIV_W'(1) : Baud_Div;
  assign word_end  = (state == SHIFT) && (dcnt == '0) && (bcnt == '0);
  // A load either starts from idle or chains straight off the last cycle of the LSB.
  assign do_load   = Enable && buf_full && ((state == IDLE) || word_end);
  assign Din_Ready = ~buf_full;
  assign Busy      = (state == SHIFT);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      buf_q      <= '0;
      buf_full   <= 1'b0;
      sreg       <= '0;
      bcnt       <= '0;
      dcnt       <= '0;
      div_q      <= DIV_W'(1);
      SW_Sel     <= IDLE_LVL;
      Sym_Strobe <= 1'b0;
      Underrun   <= 1'b0;
    end else begin
      Sym_Strobe <= 1'b0;
      Underrun   <= 1'b0;
      if (do_load) begin
        buf_full   <= 1'b0;
        sreg       <= buf_q;
        div_q      <= div_new;
        dcnt       <= div_new - DIV_W'(1);
        bcnt       <= BW'(DATA_W - 1);
        SW_Sel     <= buf_q[DATA_W-1];
        Sym_Strobe <= 1'b1;
        state      <= SHIFT;
      end else begin
        if (Din_Valid && !buf_full) begin
          buf_q    <= Din;
          buf_full <= 1'b1;
        end
        case (state)
          IDLE: SW_Sel <= IDLE_LVL;
          SHIFT: begin
            if (dcnt != '0) begin
              dcnt <= dcnt - DIV_W'(1);
            end else if (bcnt != '0) begin
              sreg       <= {sreg[DATA_W-2:0], 1'b0};
              SW_Sel     <= sreg[DATA_W-2];
              bcnt       <= bcnt - BW'(1);
              dcnt       <= div_q - DIV_W'(1);
              Sym_Strobe <= 1'b1;
            end else begin
              state    <= IDLE;
              SW_Sel   <= IDLE_LVL;
              Underrun <= Enable;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fsk_symbol_sequencer.sv
// Directed bench for fsk_symbol_sequencer with DATA_W=8; outputs sampled on the falling edge.
module tb_fsk_symbol_sequencer;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        Enable;
  logic [31:0] Baud_Div;
  logic [7:0]  Din;
  logic        Din_Valid;
  logic        Din_Ready;
  logic        SW_Sel;
  logic        Sym_Strobe;
  logic        Busy;
  logic        Underrun;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  fsk_symbol_sequencer #(.DATA_W(8), .DIV_W(32), .IDLE_LVL(1'b1)) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .Enable     (Enable),
    .Baud_Div   (Baud_Div),
    .Din        (Din),
    .Din_Valid  (Din_Valid),
    .Din_Ready  (Din_Ready),
    .SW_Sel     (SW_Sel),
    .Sym_Strobe (Sym_Strobe),
    .Busy       (Busy),
    .Underrun   (Underrun)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Offer one word for a single edge; returns just after that edge.
  task automatic drive_word(input logic [7:0] d);
    @(negedge Clock);
    Din       = d;
    Din_Valid = 1'b1;
    @(posedge Clock);
    #1 Din_Valid = 1'b0;
  endtask

  // Expects the word to start on the next falling-edge sample, div cycles per bit.
  task automatic expect_word(input string tag, input logic [7:0] w, input int div);
    for (int i = 7; i >= 0; i--) begin
      for (int c = 0; c < div; c++) begin
        @(negedge Clock);
        check({tag, "_sel"}, {31'd0, SW_Sel}, {31'd0, w[i]});
        check({tag, "_stb"}, {31'd0, Sym_Strobe}, (c == 0) ? 32'd1 : 32'd0);
        check({tag, "_busy"}, {31'd0, Busy}, 32'd1);
        check({tag, "_urun"}, {31'd0, Underrun}, 32'd0);
      end
    end
  endtask

  task automatic expect_end(input string tag, input logic exp_urun);
    @(negedge Clock);
    check({tag, "_end_urun"}, {31'd0, Underrun}, {31'd0, exp_urun});
    check({tag, "_end_sel"}, {31'd0, SW_Sel}, 32'd1);
    check({tag, "_end_busy"}, {31'd0, Busy}, 32'd0);
    @(negedge Clock);
    check({tag, "_urun_clr"}, {31'd0, Underrun}, 32'd0);
  endtask

  initial begin
    Reset_n   = 1'b0;
    Enable    = 1'b1;
    Baud_Div  = 32'd4;
    Din       = 8'h00;
    Din_Valid = 1'b0;
    repeat (2) @(posedge Clock);
    #2 Reset_n = 1'b1;

    @(negedge Clock);
    check("rst_sel", {31'd0, SW_Sel}, 32'd1);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_rdy", {31'd0, Din_Ready}, 32'd1);
    check("rst_stb", {31'd0, Sym_Strobe}, 32'd0);
    check("rst_urun", {31'd0, Underrun}, 32'd0);

    // Single word, 4-cycle bits
    drive_word(8'hA5);
    @(negedge Clock);
    check("a5_lat_rdy", {31'd0, Din_Ready}, 32'd0);
    check("a5_lat_busy", {31'd0, Busy}, 32'd0);
    expect_word("a5", 8'hA5, 4);
    expect_end("a5", 1'b1);

    // Back-to-back words, second offered while the first shifts
    Baud_Div = 32'd2;
    drive_word(8'hF0);
    @(negedge Clock);
    Din       = 8'h0F;
    Din_Valid = 1'b1;
    fork
      begin
        expect_word("f0", 8'hF0, 2);
        expect_word("0f", 8'h0F, 2);
      end
      begin
        repeat (2) @(negedge Clock);
        check("b2b_accepted", {31'd0, Din_Ready}, 32'd0);
        Din_Valid = 1'b0;
      end
    join
    expect_end("b2b", 1'b1);

    // Zero divider acts as one
    Baud_Div = 32'd0;
    drive_word(8'h81);
    @(negedge Clock);
    expect_word("81", 8'h81, 1);
    expect_end("81", 1'b1);

    // Enable dropped mid-word with a word buffered
    Baud_Div = 32'd4;
    drive_word(8'hFF);
    @(negedge Clock);
    Din       = 8'h3C;
    Din_Valid = 1'b1;
    fork
      expect_word("ff", 8'hFF, 4);
      begin
        repeat (2) @(negedge Clock);
        Din_Valid = 1'b0;
        repeat (7) @(negedge Clock);
        Enable = 1'b0;
      end
    join
    @(negedge Clock);
    check("en_off_urun", {31'd0, Underrun}, 32'd0);
    check("en_off_sel", {31'd0, SW_Sel}, 32'd1);
    check("en_off_busy", {31'd0, Busy}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      check("en_off_rdy", {31'd0, Din_Ready}, 32'd0);
      check("en_off_idle", {31'd0, Busy}, 32'd0);
    end
    Enable = 1'b1;
    expect_word("3c", 8'h3C, 4);
    expect_end("3c", 1'b1);

    // Divider change mid-word applies to the next word
    Baud_Div = 32'd4;
    drive_word(8'hC3);
    @(negedge Clock);
    Din       = 8'h5A;
    Din_Valid = 1'b1;
    fork
      begin
        expect_word("c3", 8'hC3, 4);
        expect_word("5a", 8'h5A, 3);
      end
      begin
        repeat (2) @(negedge Clock);
        Din_Valid = 1'b0;
        repeat (3) @(negedge Clock);
        Baud_Div = 32'd3;
      end
    join
    expect_end("div", 1'b1);

    // Asynchronous reset in the middle of a 0 bit
    Baud_Div = 32'd4;
    drive_word(8'hAA);
    @(negedge Clock);
    repeat (6) @(negedge Clock);
    check("pre_rst_sel", {31'd0, SW_Sel}, 32'd0);
    #2 Reset_n = 1'b0;
    #1;
    check("arst_sel", {31'd0, SW_Sel}, 32'd1);
    check("arst_busy", {31'd0, Busy}, 32'd0);
    check("arst_rdy", {31'd0, Din_Ready}, 32'd1);
    check("arst_stb", {31'd0, Sym_Strobe}, 32'd0);
    @(negedge Clock);
    Reset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clock);
      check("post_rst_stb", {31'd0, Sym_Strobe}, 32'd0);
      check("post_rst_sel", {31'd0, SW_Sel}, 32'd1);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
